// File: rtl/cursor_uart_rx.sv
// cursor_uart_rx: 8N1 UART receiver and cursor packet decoder.
// Packets are a header byte (101000rl), then dx, then dy, all signed bytes.
// Optional macro CURSOR_RX_CHECKSUM_EN adds a 4th byte equal to hdr ^ dx ^ dy.
module cursor_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned TIMEOUT_CLKS = 43400
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       pkt_valid,
    output logic       left_click,
    output logic       right_click,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic       frame_err,
    output logic       sync_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CLKS - 1);
    localparam logic [5:0]       HDR_TAG   = 6'b101000;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [1:0] {P_HDR, P_DX, P_DY, P_CK} pkt_state_t;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;

    bit_state_t       bit_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             stop_wait;
    logic             byte_done;
    logic [7:0]       byte_data;
    logic             stop_fail;

    pkt_state_t       pkt_state;
    logic [GAP_W-1:0] gap_cnt;
    logic             sh_left;
    logic             sh_right;
    logic [7:0]       sh_dx;
`ifdef CURSOR_RX_CHECKSUM_EN
    logic [7:0]       sh_dy;
    logic [7:0]       sh_hdr;
`endif

    // Stop bit is being sampled low on this edge; frame_err wins over any sync_err.
    assign stop_fail = (bit_state == B_STOP) && !stop_wait &&
                       (bit_cnt == BIT_LAST) && !rx_sync;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit-level FSM: start-bit qualification, mid-bit sampling, stop check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_state <= B_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            stop_wait <= 1'b0;
            byte_done <= 1'b0;
            byte_data <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            case (bit_state)
                B_IDLE: begin
                    bit_cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        bit_state <= B_START;
                    end
                end
                B_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (!rx_sync) begin
                            bit_idx   <= '0;
                            bit_state <= B_DATA;
                        end else begin
                            bit_state <= B_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                B_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            bit_state <= B_STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                B_STOP: begin
                    if (stop_wait) begin
                        // Hold here until the line returns high so a stuck-low line cannot re-trigger.
                        if (rx_sync) begin
                            stop_wait <= 1'b0;
                            bit_state <= B_IDLE;
                        end
                    end else if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rx_sync) begin
                            byte_done <= 1'b1;
                            byte_data <= shift;
                            bit_state <= B_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            stop_wait <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                default: bit_state <= B_IDLE;
            endcase
        end
    end

    // Packet FSM: header check, shadow capture, atomic output update, timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_state   <= P_HDR;
            gap_cnt     <= '0;
            sh_left     <= 1'b0;
            sh_right    <= 1'b0;
            sh_dx       <= '0;
`ifdef CURSOR_RX_CHECKSUM_EN
            sh_dy       <= '0;
            sh_hdr      <= '0;
`endif
            pkt_valid   <= 1'b0;
            sync_err    <= 1'b0;
            left_click  <= 1'b0;
            right_click <= 1'b0;
            dx          <= '0;
            dy          <= '0;
        end else begin
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            if (frame_err) begin
                pkt_state <= P_HDR;
                gap_cnt   <= '0;
            end else if (pkt_state == P_HDR) begin
                gap_cnt <= '0;
                if (byte_done) begin
                    if (byte_data[7:2] == HDR_TAG) begin
                        sh_right  <= byte_data[1];
                        sh_left   <= byte_data[0];
`ifdef CURSOR_RX_CHECKSUM_EN
                        sh_hdr    <= byte_data;
`endif
                        pkt_state <= P_DX;
                    end else begin
                        sync_err <= 1'b1;
                    end
                end
            end else if (byte_done) begin
                // A completing byte beats a timeout landing on the same edge.
                gap_cnt <= '0;
                case (pkt_state)
                    P_DX: begin
                        sh_dx     <= byte_data;
                        pkt_state <= P_DY;
                    end
                    P_DY: begin
`ifdef CURSOR_RX_CHECKSUM_EN
                        sh_dy     <= byte_data;
                        pkt_state <= P_CK;
`else
                        left_click  <= sh_left;
                        right_click <= sh_right;
                        dx          <= sh_dx;
                        dy          <= byte_data;
                        pkt_valid   <= 1'b1;
                        pkt_state   <= P_HDR;
`endif
                    end
`ifdef CURSOR_RX_CHECKSUM_EN
                    P_CK: begin
                        if (byte_data == (sh_hdr ^ sh_dx ^ sh_dy)) begin
                            left_click  <= sh_left;
                            right_click <= sh_right;
                            dx          <= sh_dx;
                            dy          <= sh_dy;
                            pkt_valid   <= 1'b1;
                        end else begin
                            sync_err <= 1'b1;
                        end
                        pkt_state <= P_HDR;
                    end
`endif
                    default: pkt_state <= P_HDR;
                endcase
            end else if (gap_cnt == GAP_LAST) begin
                gap_cnt   <= '0;
                sh_left   <= 1'b0;
                sh_right  <= 1'b0;
                sh_dx     <= '0;
                sync_err  <= !stop_fail;
                pkt_state <= P_HDR;
            end else begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule

// File: doc/cursor_uart_rx.md
Name: cursor_uart_rx

Overview:
UART receiver and packet decoder for the cursor link; it is the far end of the cursor packet transmitter. It deserialises 8N1 bytes from the serial line and frames them into cursor packets: a header carrying the click bits, then dx, then dy. Each good packet is presented as registered click/dx/dy outputs with a one-cycle valid strobe. It is used in the host-side bridge FPGA and in loopback benches against the transmitter.

Parameters:
CLKS_PER_BIT, 434, clocks per UART bit (50 MHz / 115200); minimum 8.
TIMEOUT_CLKS, 43400, maximum idle clocks between bytes of one packet before the partial packet is dropped.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
pkt_valid  out  1  one-cycle pulse: new packet on outputs
left_click  out  1  left click bit of last good packet
right_click  out  1  right click bit of last good packet
dx  out  8  signed dx of last good packet
dy  out  8  signed dy of last good packet
frame_err  out  1  one-cycle pulse: stop bit sampled low
sync_err  out  1  one-cycle pulse: bad header, inter-byte timeout, or checksum mismatch

Behaviour:
- Reset: all outputs 0. Both synchroniser flops reset to 1. Bit FSM goes to IDLE, packet FSM to HDR, all counters 0.
- rx passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Bit FSM (IDLE, START, DATA, STOP):
  - IDLE: a 1→0 transition starts the bit counter; go to START.
  - START: at CLKS_PER_BIT/2 (integer division) sample the line. Low: go to DATA. High: glitch, return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT from the start-bit midpoint; 8 bits, LSB first.
  - STOP: sample one CLKS_PER_BIT later.
    - High: byte_done for one cycle, return to IDLE.
    - Low: frame_err pulses, the byte is discarded, the packet FSM returns to HDR, and the bit FSM waits in STOP until the line is high, then goes to IDLE (no re-trigger on a held-low line).
- Packet FSM (HDR, DX, DY):
  - HDR: on byte_done, accept the byte if bits[7:2]==6'b101000. Latch bit1 as right and bit0 as left into shadow registers; go to DX. Otherwise pulse sync_err and stay in HDR.
  - DX: on byte_done, latch the shadow dx; go to DY.
  - DY: on byte_done, copy all shadows plus this byte (as dy) to the outputs. pkt_valid pulses in the same cycle the outputs update, which is 1 cycle after byte_done. Return to HDR.
- Latency: pkt_valid asserts 1 clock after the stop-bit sample of the final byte.
- Outputs hold the last good packet. No partial update ever reaches them.
- Timeout: in DX or DY, a gap counter reset by each byte_done counts clocks. When it reaches TIMEOUT_CLKS: pulse sync_err, drop the shadows, go to HDR. A byte completing in the same cycle as the timeout takes priority (no timeout).
- A header-pattern byte received in DX or DY is treated as data, not a resync.
- Reset mid-byte or mid-packet aborts everything immediately. No pulse is emitted.
- frame_err and sync_err never assert in the same cycle. frame_err takes priority.

Optional Feature:
CURSOR_RX_CHECKSUM_EN.
- Defined: packets are 4 bytes. A CK state follows DY. The 4th byte must equal header XOR dx XOR dy.
  - Match: outputs update and pkt_valid pulses 1 cycle after the CK byte_done.
  - Mismatch: sync_err pulses, outputs unchanged.
  - The timeout applies in CK as well.
- Undefined: 3-byte packets as above, no CK state.

Test Plan:
- CLKS_PER_BIT=16. Send 0xA1, 0x05, 0xFB → pkt_valid once; left_click=1, right_click=0, dx=5, dy=-5.
- Send 0x55, then 0xA2, 0x7F, 0x80 → one sync_err pulse on 0x55; then pkt_valid with right_click=1, dx=127, dy=-128.
- Send 0xA0 with its stop bit held low for 2 bit times, then 0xA0, 0x01, 0x02 → frame_err once, no spurious byte; pkt_valid with dx=1, dy=2.
- Send 0xA3, 0x10, then idle for TIMEOUT_CLKS+10 → sync_err once, no pkt_valid, outputs keep the prior packet.
- Drive a 4-clock low glitch on rx in IDLE → no byte, no errors. Assert rst_n low mid-DX byte → all outputs 0; the next full packet decodes correctly.
- With CURSOR_RX_CHECKSUM_EN: send 0xA1, 0x05, 0xFB, 0x5F → pkt_valid. Send 0xA1, 0x05, 0xFB, 0x00 → sync_err, no pkt_valid.
